// File: rtl/tcdm_bank_responder.sv
// TCDM bank responder: req/gnt slave port over a word array with
// an init/clear sequencer and a fixed-latency read response pipeline.
//
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   req_i, gnt_o    bank request / combinational grant
//   add_i           word address
//   wen_i           1 = store, 0 = load
//   wdata_i, be_i   write data and byte enables
//   rdata_o         read data, RespLat cycles after a granted load, else 0
//   stall_i         backpressure, suppresses grants
//   clear_i         pulse requesting re-initialisation of the array
//   init_done_o     high while the bank is serving requests
module tcdm_bank_responder #(
   parameter int unsigned          AddrMemWidth = 8,
   parameter int unsigned          DataWidth    = 32,
   parameter int unsigned          BeWidth      = DataWidth / 8,
   parameter int unsigned          RespLat      = 1,
   parameter logic [DataWidth-1:0] InitValue    = '0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_i,
   output logic                    gnt_o,
   input  logic [AddrMemWidth-1:0] add_i,
   input  logic                    wen_i,
   input  logic [DataWidth-1:0]    wdata_i,
   input  logic [BeWidth-1:0]      be_i,
   output logic [DataWidth-1:0]    rdata_o,
   input  logic                    stall_i,
   input  logic                    clear_i,
   output logic                    init_done_o
);

   localparam int unsigned NumWords = 2 ** AddrMemWidth;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_READY,
      ST_DRAIN
   } state_e;

   state_e                  r_state;
   logic [AddrMemWidth-1:0] r_cnt;
   logic                    r_init_done;
   logic [RespLat-1:0]      r_vld;
   logic [DataWidth-1:0]    r_data [RespLat];
   logic [DataWidth-1:0]    r_mem  [NumWords];

   logic w_gnt;
   logic w_acc_rd;
   logic w_acc_wr;
   logic w_pipe_empty;

   // rst_ni is folded in so no grant can escape while reset is held
   assign w_gnt        = rst_ni & req_i & (r_state == ST_READY)
                       & ~stall_i & ~clear_i;
   assign w_acc_rd     = w_gnt & ~wen_i;
   assign w_acc_wr     = w_gnt & wen_i;
   assign w_pipe_empty = ~|r_vld;

   assign gnt_o       = w_gnt;
   assign init_done_o = r_init_done;
   assign rdata_o     = r_vld[RespLat-1] ? r_data[RespLat-1] : '0;

   // init_done is updated together with the state so it mirrors READY
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state     <= ST_INIT;
         r_cnt       <= '0;
         r_init_done <= 1'b0;
      end else begin
         unique case (r_state)
            ST_INIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (&r_cnt) begin
                  r_state     <= ST_READY;
                  r_init_done <= 1'b1;
               end
            end
            ST_READY: begin
               if (clear_i) begin
                  r_init_done <= 1'b0;
                  r_cnt       <= '0;
                  r_state     <= w_pipe_empty ? ST_INIT : ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (w_pipe_empty) begin
                  r_state <= ST_INIT;
                  r_cnt   <= '0;
               end
            end
            default: begin
               r_state     <= ST_INIT;
               r_cnt       <= '0;
               r_init_done <= 1'b0;
            end
         endcase
      end
   end

   // Response shift register; data is sampled from the array at accept
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_vld <= '0;
         for (int i = 0; i < int'(RespLat); i++) begin
            r_data[i] <= '0;
         end
      end else begin
         r_vld[0]  <= w_acc_rd;
         r_data[0] <= w_acc_rd ? r_mem[add_i] : '0;
         for (int i = 1; i < int'(RespLat); i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_data[i] <= r_data[i-1];
         end
      end
   end

   // Array has no reset; INIT overwrites every word after reset
   always_ff @(posedge clk_i) begin
      if (rst_ni && (r_state == ST_INIT)) begin
         r_mem[r_cnt] <= InitValue;
      end else if (w_acc_wr) begin
         for (int b = 0; b < int'(BeWidth); b++) begin
            if (be_i[b]) begin
               r_mem[add_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Scoreboard bench for tcdm_bank_responder: directed scenarios then
// random traffic, checked against a behavioural bank model.
module tb_tcdm_bank_responder;

   localparam int LAT = 3;

   logic        clk;
   logic        rst_ni;
   logic        req_i;
   logic        gnt_o;
   logic [7:0]  add_i;
   logic        wen_i;
   logic [31:0] wdata_i;
   logic [3:0]  be_i;
   logic [31:0] rdata_o;
   logic        stall_i;
   logic        clear_i;
   logic        init_done_o;

   tcdm_bank_responder #(
      .AddrMemWidth(8),
      .DataWidth   (32),
      .BeWidth     (4),
      .RespLat     (LAT),
      .InitValue   (32'h0)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_ni),
      .req_i      (req_i),
      .gnt_o      (gnt_o),
      .add_i      (add_i),
      .wen_i      (wen_i),
      .wdata_i    (wdata_i),
      .be_i       (be_i),
      .rdata_o    (rdata_o),
      .stall_i    (stall_i),
      .clear_i    (clear_i),
      .init_done_o(init_done_o)
   );

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          n_chk  = 0;
   int          n_fail = 0;
   int          cyc    = 0;
   bit          mon_en = 0;
   logic [31:0] mm [256];
   bit          m_ready = 0;
   bit          m_drain = 0;
   int          m_left  = 0;
   int          m_last_due = -1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: every cycle rdata_o is either the due response or zero
   always @(negedge clk) begin
      logic [31:0] e;
      if (mon_en) begin
         e = 32'h0;
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb[0].data;
            void'(sb.pop_front());
         end
         chk("rdata", rdata_o, e);
         chk("init_done", {31'h0, init_done_o}, {31'h0, m_ready});
      end
   end

   // One clock cycle of stimulus plus the reference model update
   task automatic step(input logic rst, input logic req, input logic wen,
                       input logic [7:0] add, input logic [31:0] wd,
                       input logic [3:0] be, input logic stall,
                       input logic clr);
      logic eg;
      @(negedge clk);
      rst_ni  = rst;
      req_i   = req;
      wen_i   = wen;
      add_i   = add;
      wdata_i = wd;
      be_i    = be;
      stall_i = stall;
      clear_i = clr;
      #1;
      eg = rst & req & m_ready & ~stall & ~clr;
      chk("gnt", {31'h0, gnt_o}, {31'h0, eg});
      @(posedge clk);
      if (!rst) begin
         sb.delete();
         m_ready    = 0;
         m_drain    = 0;
         m_left     = 256;
         m_last_due = -1;
      end else begin
         if (eg) begin
            if (wen) begin
               for (int b = 0; b < 4; b++)
                  if (be[b]) mm[add][b*8 +: 8] = wd[b*8 +: 8];
            end else begin
               sb.push_back('{due: cyc + LAT, data: mm[add]});
               m_last_due = cyc + LAT;
            end
         end
         if (m_ready) begin
            if (clr) begin
               m_ready = 0;
               if (m_last_due < cyc) m_left = 256;
               else m_drain = 1;
            end
         end else if (m_drain) begin
            if (m_last_due < cyc) begin
               m_drain = 0;
               m_left  = 256;
            end
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               foreach (mm[i]) mm[i] = 32'h0;
               m_ready = 1;
            end
         end
      end
      cyc++;
   endtask

   task automatic idle();
      step(1, 0, 0, 8'h0, 32'h0, 4'h0, 0, 0);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] be);
      step(1, 1, 1, a, d, be, 0, 0);
   endtask

   task automatic rd(input logic [7:0] a);
      step(1, 1, 0, a, 32'h0, 4'h0, 0, 0);
   endtask

   initial begin
      rst_ni  = 1'b0;
      req_i   = 1'b0;
      wen_i   = 1'b0;
      add_i   = '0;
      wdata_i = '0;
      be_i    = '0;
      stall_i = 1'b0;
      clear_i = 1'b0;

      repeat (2) step(0, 1, 0, 8'h0, 32'h0, 4'h0, 0, 0);
      mon_en = 1;

      // reset hit part-way through INIT restarts the full sequence
      repeat (100) rd(8'h00);
      step(0, 1, 0, 8'h0, 32'h0, 4'h0, 0, 0);
      repeat (262) rd(8'h00);
      repeat (LAT + 1) idle();

      // byte-enable merge
      wr(8'h12, 32'hDEADBEEF, 4'hF);
      wr(8'h12, 32'h11223344, 4'h5);
      rd(8'h12);
      wr(8'h13, 32'hCAFEF00D, 4'h0);
      rd(8'h13);
      repeat (LAT + 1) idle();

      // back-to-back reads
      wr(8'h01, 32'hA1, 4'hF);
      wr(8'h02, 32'hA2, 4'hF);
      wr(8'h03, 32'hA3, 4'hF);
      rd(8'h01);
      rd(8'h02);
      rd(8'h03);
      repeat (LAT + 2) idle();

      // stall blocks grants and leaves the array untouched
      wr(8'h20, 32'h01020304, 4'hF);
      rd(8'h20);
      repeat (5) step(1, 1, 1, 8'h20, 32'hFFFFFFFF, 4'hF, 1, 0);
      rd(8'h20);
      repeat (LAT + 1) idle();

      // clear with a read in flight: drain, re-init, word reads zero
      wr(8'h05, 32'h55, 4'hF);
      rd(8'h05);
      step(1, 1, 0, 8'h05, 32'h0, 4'h0, 0, 1);
      for (int i = 0; i < 400 && !m_ready; i++) rd(8'h05);
      rd(8'h05);
      repeat (LAT + 1) idle();

      // random traffic with occasional stall and clear
      for (int i = 0; i < 2000; i++) begin
         step(1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 15)), $urandom, 4'($urandom),
              $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
      end
      repeat (LAT + 2) idle();
      chk("sb_empty", 32'(sb.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tcdm_bank_responder.md
Name: tcdm_bank_responder

Overview:
- Bank-side responder for one TCDM interconnect slave port: accepts req/gnt bank requests, stores data in an internal word array, returns read data at a fixed latency.
- Used as the synthesizable bank model behind each interconnect output in cluster testbenches and FPGA builds.
- Contains an init/clear state machine that zeroes the array, and a response latency pipeline matched to the interconnect's RespLat.

Parameters:
- AddrMemWidth, 8, word-address bits; depth NumWords = 2**AddrMemWidth.
- DataWidth, 32, word width.
- BeWidth, DataWidth/8, byte-enable width.
- RespLat, 1, cycles from granted read to rdata_o; legal range 1..4.
- InitValue, '0, value written to every word during init.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- req_i  in  1  bank request.
- gnt_o  out  1  bank grant.
- add_i  in  AddrMemWidth  word address.
- wen_i  in  1  1 = store, 0 = load.
- wdata_i  in  DataWidth  write data.
- be_i  in  BeWidth  byte enables.
- rdata_o  out  DataWidth  read data.
- stall_i  in  1  external backpressure; grants are suppressed while high.
- clear_i  in  1  pulse that requests re-initialisation of the array.
- init_done_o  out  1  high in READY state.

Behaviour:
- Single clock domain. Reset is synchronous and active-low and is sampled on the clk_i rising edge. Clock is clk_i, reset is rst_ni.
- Reset (any clk_i edge with rst_ni=0) forces the following values:
  - state = INIT, init counter = 0, pipeline valid bits = 0.
  - gnt_o = 0, rdata_o = 0, init_done_o = 0.
  - Array contents are not reset; they are overwritten by INIT.
- States:
  - INIT: writes InitValue to word[counter] each cycle; counter increments. When counter = NumWords-1 is written, go to READY. Takes exactly NumWords cycles. gnt_o = 0.
  - READY: serves requests. If clear_i = 1 this cycle, go to DRAIN (or straight to INIT if the pipeline is empty).
  - DRAIN: gnt_o = 0; stays until all pipeline valid bits are 0, then INIT with counter = 0.
- clear_i is ignored in INIT and DRAIN.
- Reset asserted mid-INIT or mid-DRAIN restarts INIT from 0. In-flight responses are discarded and rdata_o returns to 0.
- Grant: gnt_o = req_i & (state==READY) & ~stall_i & ~clear_i, combinational. A request is accepted when req_i & gnt_o.
- Write (wen_i=1, accepted): byte i of word[add_i] takes wdata_i byte i when be_i[i] = 1 and is unchanged otherwise. be_i = 0 is a legal no-op write.
- Read (wen_i=0, accepted): word[add_i] is sampled at the accept edge. rdata_o presents it exactly RespLat cycles after the accept cycle, for one cycle. be_i is ignored for reads.
- rdata_o is 0 in every cycle that carries no read response, including write response slots.
- Ordering:
  - Write followed by read of the same address on the next cycle returns the new data.
  - Back-to-back reads give one response per cycle, in order.
- Pipeline: RespLat-deep shift of {valid, data}. Fully pipelined, one accept per cycle, no bubbles.
- clear_i or stall_i asserted while responses are in flight does not drop or delay those responses.
- init_done_o = (state==READY), registered.
- Address wrap: add_i is always in range by width; no aliasing.

Test Plan:
- Reset, then hold req_i=1, wen_i=0, add_i=0 → gnt_o=0 and init_done_o=0 for 256 cycles, then init_done_o=1; the first grant follows and rdata_o=0x00000000 RespLat cycles later.
- After init, write add=0x12 data=0xDEADBEEF be=0xF, then write add=0x12 data=0x11223344 be=0x5, then read add=0x12 → rdata_o=0xDE22BE44 exactly RespLat cycles after the read is granted.
- RespLat=3: reads to add 1, 2, 3 on consecutive cycles (preloaded with 0xA1, 0xA2, 0xA3) → rdata_o=0xA1, 0xA2, 0xA3 on cycles +3, +4, +5; rdata_o=0 on all other cycles.
- stall_i=1 for 5 cycles with req_i=1 → gnt_o=0 for those cycles, no array change; the request is granted on the first cycle after stall_i drops.
- RespLat=2: clear_i pulses in the same cycle a read of add=0x05 (value 0x55) is requested → no grant that cycle. A read granted the cycle before still returns its data. DRAIN lasts until the pipeline is empty, then INIT for 256 cycles, after which a read of 0x05 returns 0.
- rst_ni low for one edge at INIT counter=100 → counter restarts; init_done_o rises 256 cycles after reset deassertion, not 156.
